// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing constants shared by the VGA ROM reader.
package vga_timing_pkg;
    localparam int VGA_H_ACTIVE   = 640;
    localparam int VGA_H_FP       = 16;
    localparam int VGA_H_SYNC     = 96;
    localparam int VGA_H_BP       = 48;
    localparam int VGA_H_TOTAL    = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_ACTIVE   = 480;
    localparam int VGA_V_FP       = 10;
    localparam int VGA_V_SYNC     = 2;
    localparam int VGA_V_BP       = 33;
    localparam int VGA_V_TOTAL    = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam int VGA_DATA_WIDTH = 24;
    localparam int VGA_ADDR_WIDTH = 24;
endpackage

// File: rtl/vga_rom_reader_if.sv
// vga_rom_reader_if: pixel-tick control, ROM port and video outputs of the VGA ROM reader.
interface vga_rom_reader_if
    import vga_timing_pkg::*;
#(
    parameter int DATA_WIDTH = VGA_DATA_WIDTH
);
    logic                      pix_ce;
    logic                      blank_en;
    logic [VGA_ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0]     rom_rdata;
    logic [7:0]                red;
    logic [7:0]                green;
    logic [7:0]                blue;
    logic                      hsync;
    logic                      vsync;
    logic                      de;
    logic                      frame_start;

    modport slave (
        input  pix_ce, blank_en, rom_rdata,
        output rom_addr, red, green, blue, hsync, vsync, de, frame_start
    );

    modport master (
        output pix_ce, blank_en, rom_rdata,
        input  rom_addr, red, green, blue, hsync, vsync, de, frame_start
    );
endinterface

// File: rtl/vga_timing.sv
// vga_timing: h/v raster counters with stage-0 active, sync and frame-origin decode.
module vga_timing
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pix_ce,
    output logic o_active,
    output logic o_hsync,
    output logic o_vsync,
    output logic o_origin
);
    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (i_pix_ce) begin
            r_h_cnt <= (r_h_cnt == H_LAST) ? '0 : r_h_cnt + HW'(1);
            if (r_h_cnt == H_LAST)
                r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + VW'(1);
        end
    end

    assign o_active = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    assign o_hsync  = !((r_h_cnt >= H_SS) && (r_h_cnt < H_SE));
    assign o_vsync  = !((r_v_cnt >= V_SS) && (r_v_cnt < V_SE));
    assign o_origin = (r_h_cnt == '0) && (r_v_cnt == '0);
endmodule

// File: rtl/vga_rom_reader.sv
// vga_rom_reader: streams a frame-sized pixel ROM onto VGA timing through a two-stage pipeline.
module vga_rom_reader
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = VGA_H_ACTIVE,
    parameter int H_FP       = VGA_H_FP,
    parameter int H_SYNC     = VGA_H_SYNC,
    parameter int H_BP       = VGA_H_BP,
    parameter int V_ACTIVE   = VGA_V_ACTIVE,
    parameter int V_FP       = VGA_V_FP,
    parameter int V_SYNC     = VGA_V_SYNC,
    parameter int V_BP       = VGA_V_BP,
    parameter int DATA_WIDTH = VGA_DATA_WIDTH
) (
    input logic             clk,
    input logic             rst,
    vga_rom_reader_if.slave bus
);
    logic                      w_active, w_hsync, w_vsync, w_origin;
    logic [VGA_ADDR_WIDTH-1:0] r_rom_addr;
    logic                      r_active1, r_hsync1, r_vsync1, r_origin1;
    logic [DATA_WIDTH-1:0]     r_pixel;
    logic                      r_de, r_hsync, r_vsync, r_frame_start;

    vga_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk      (clk),
        .rst      (rst),
        .i_pix_ce (bus.pix_ce),
        .o_active (w_active),
        .o_hsync  (w_hsync),
        .o_vsync  (w_vsync),
        .o_origin (w_origin)
    );

    // Address advances only on active pixels, so blanking holds the last fetched word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rom_addr    <= '0;
            r_active1     <= 1'b0;
            r_hsync1      <= 1'b1;
            r_vsync1      <= 1'b1;
            r_origin1     <= 1'b0;
            r_pixel       <= '0;
            r_de          <= 1'b0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= bus.pix_ce && r_origin1;
            if (bus.pix_ce) begin
                r_rom_addr <= w_origin ? '0 : w_active ? r_rom_addr + 24'd1 : r_rom_addr;
                r_active1  <= w_active;
                r_hsync1   <= w_hsync;
                r_vsync1   <= w_vsync;
                r_origin1  <= w_origin;
                r_pixel    <= (r_active1 && !bus.blank_en) ? bus.rom_rdata : '0;
                r_de       <= r_active1;
                r_hsync    <= r_hsync1;
                r_vsync    <= r_vsync1;
            end
        end
    end

    assign bus.rom_addr    = r_rom_addr;
    assign bus.red         = r_pixel[23:16];
    assign bus.green       = r_pixel[15:8];
    assign bus.blue        = r_pixel[7:0];
    assign bus.de          = r_de;
    assign bus.hsync       = r_hsync;
    assign bus.vsync       = r_vsync;
    assign bus.frame_start = r_frame_start;
endmodule

// File: tb/tb_vga_rom_reader.sv
// tb_vga_rom_reader: scoreboard bench for vga_rom_reader on a reduced 16x8 raster.
module tb_vga_rom_reader;
    localparam int HA  = 16, HFP = 2, HS = 4, HBP = 3;
    localparam int VA  = 8,  VFP = 2, VS = 2, VBP = 3;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;
    localparam int BL  = 3;

    typedef struct packed {
        logic [23:0] rgb;
        logic [23:0] addr;
        logic        de;
        logic        hs;
        logic        vs;
        logic        fs;
    } exp_t;

    typedef struct {
        int h;
        int v;
        bit ok;
    } pos_t;

    localparam exp_t RST = '{rgb: 24'd0, addr: 24'd0, de: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    pos_t p0, p1, p2;
    bit   blank_on = 1'b0;

    vga_rom_reader_if #(.DATA_WIDTH(24)) bus();

    vga_rom_reader #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .DATA_WIDTH(24)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // synchronous ROM whose word equals its address
    always @(posedge clk) bus.rom_rdata <= bus.rom_addr;

    function automatic int addr_of(pos_t p);
        if (p.v >= VA) return HA * VA - 1;
        if (p.h >= HA) return p.v * HA + HA - 1;
        return p.v * HA + p.h;
    endfunction

    function automatic exp_t model(pos_t s2, pos_t s1, logic blank);
        exp_t e;
        logic act;
        act    = s2.ok && s2.h < HA && s2.v < VA;
        e.addr = s1.ok ? 24'(addr_of(s1)) : 24'd0;
        e.de   = act;
        e.rgb  = (act && !blank) ? 24'(s2.v * HA + s2.h) : 24'd0;
        e.hs   = !(s2.ok && s2.h >= HA + HFP && s2.h < HA + HFP + HS);
        e.vs   = !(s2.ok && s2.v >= VA + VFP && s2.v < VA + VFP + VS);
        e.fs   = s2.ok && s2.h == 0 && s2.v == 0;
        return e;
    endfunction

    task automatic chk(string name, int got, int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // one pixel tick every fourth clock
    task automatic tick();
        @(negedge clk);
        bus.blank_en = blank_on && p1.ok && p1.v == BL;
        p2 = p1;
        p1 = p0;
        p0.h = (p0.h == HT - 1) ? 0 : p0.h + 1;
        if (p0.h == 0) p0.v = (p0.v == VT - 1) ? 0 : p0.v + 1;
        exp_q.push_back(model(p2, p1, bus.blank_en));
        bus.pix_ce = 1'b1;
        @(negedge clk);
        bus.pix_ce = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        p0 = '{0, 0, 1'b1};
        p1 = '{0, 0, 1'b0};
        p2 = '{0, 0, 1'b0};
        exp_q.delete();
        repeat (5) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_to(int h, int v);
        for (int i = 0; i < 2 * HT * VT; i++) begin
            if (p0.h == h && p0.v == v) return;
            tick();
        end
        checks++;
        failures++;
        $display("FAIL run_to: position (%0d,%0d) not reached, at (%0d,%0d)", h, v, p0.h, p0.v);
    endtask

    initial begin
        exp_t cur, e, got;
        bit   ce, seen, larm, last_hs;
        int   ft, nde, nhs, nvs, lt;
        string name;
        cur = RST;
        seen = 1'b0; larm = 1'b0; last_hs = 1'b1;
        ft = 0; nde = 0; nhs = 0; nvs = 0; lt = 0;
        @(negedge rst);
        forever begin
            @(posedge clk);
            ce = bus.pix_ce;
            #1;
            got = {bus.red, bus.green, bus.blue, bus.rom_addr, bus.de, bus.hsync, bus.vsync, bus.frame_start};
            name = !rst ? "reset" : ce ? "pixel" : "hold";
            if (!rst) begin
                e = RST;
                seen = 1'b0;
                larm = 1'b0;
                last_hs = 1'b1;
            end else if (!ce) begin
                e = cur;
            end else if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow: output tick with no expected entry");
                e = cur;
            end else begin
                e = exp_q.pop_front();
            end
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL %s: got rgb=%h addr=%0d de=%b hs=%b vs=%b fs=%b expected rgb=%h addr=%0d de=%b hs=%b vs=%b fs=%b",
                         name, got.rgb, got.addr, got.de, got.hs, got.vs, got.fs,
                         e.rgb, e.addr, e.de, e.hs, e.vs, e.fs);
            end
            cur = e;
            cur.fs = 1'b0;
            if (rst && ce) begin
                if (got.fs) begin
                    if (seen) begin
                        chk("frame_ticks", ft, HT * VT);
                        chk("de_ticks", nde, HA * VA);
                        chk("hsync_low_ticks", nhs, HS * VT);
                        chk("vsync_low_ticks", nvs, VS * HT);
                    end
                    seen = 1'b1;
                    ft = 0; nde = 0; nhs = 0; nvs = 0;
                end
                ft++;
                nde += int'(got.de);
                nhs += int'(!got.hs);
                nvs += int'(!got.vs);
                if (last_hs && !got.hs) begin
                    if (larm) chk("line_ticks", lt, HT);
                    larm = 1'b1;
                    lt = 0;
                end
                lt++;
                last_hs = got.hs;
            end
        end
    end

    initial begin
        bus.pix_ce = 1'b0;
        bus.blank_en = 1'b0;
        #1 rst = 1'b0;
        do_reset();
        repeat (3) @(negedge clk);
        repeat (HT * VT + 3) tick();
        blank_on = 1'b1;
        run_to(0, BL + 2);
        blank_on = 1'b0;
        run_to(5, 6);
        repeat (50) @(negedge clk);
        run_to(HA / 2, VA / 2);
        run_to(HA / 2, VA / 2 + 1);
        run_to(HA / 2, VA / 2);
        do_reset();
        repeat (2 * HT * VT + 5) tick();
        repeat (8) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: got %0d pending entries expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vga_rom_reader.md
VGA_ROM_READER -- requirements
Module: vga_rom_reader

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal porch and sync widths in pixels (line total 800).
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL have parameters V_FP/V_SYNC/V_BP, defaults 10/2/33, vertical porch and sync widths in lines (frame total 525).
REQ-005 SHALL have parameter DATA_WIDTH, default 24, ROM word width (R[23:16], G[15:8], B[7:0]).
REQ-006 SHALL have port clk, input, 1, single system clock; all logic on rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port pix_ce, input, 1, pixel-tick enable; asserted for at most one clk in any two consecutive clks.
REQ-009 SHALL have port blank_en, input, 1, when high forces RGB outputs to 0 while timing continues.
REQ-010 SHALL have port rom_addr, output, 24, linear read address to the synchronous pixel ROM.
REQ-011 SHALL have port rom_rdata, input, DATA_WIDTH, ROM read data, valid one clk after rom_addr changes.
REQ-012 SHALL have ports red/green/blue, output, 8 each, registered pixel colour.
REQ-013 SHALL have ports hsync/vsync, output, 1 each, active-low sync pulses.
REQ-014 SHALL have port de, output, 1, high during visible pixels, aligned with RGB.
REQ-015 SHALL have port frame_start, output, 1, one-clk pulse when pixel (0,0) is presented on RGB.

Function
REQ-016 SHALL keep h_cnt 0..799 and v_cnt 0..524, advancing only on pix_ce; h wraps 799->0 and increments v; v wraps 524->0.
REQ-017 SHALL treat a pixel as active when h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
REQ-018 SHALL assert stage-1 hsync low for h_cnt in [656,751] and vsync low for v_cnt in [490,491].
REQ-019 SHALL generate rom_addr by increment, with no multiplier: 0 on the pix_ce for (0,0), +1 per active pixel, held during blanking.
REQ-020 SHALL register rom_addr, active, hsync and vsync as stage 1 on pix_ce.
REQ-021 SHALL register stage 2 on the next pix_ce: RGB = rom_rdata when stage-1 active and blank_en low, else 0; hsync/vsync/de copied from stage 1.
REQ-022 SHALL present pixel (h,v) on outputs exactly 2 pix_ce ticks after the counters reach (h,v); the sync pulses are delayed identically.
REQ-023 SHALL make the last active address H_ACTIVE*V_ACTIVE-1 (307199 by default) and return rom_addr to 0 at the next frame.
REQ-024 SHALL hold all state and outputs unchanged when pix_ce is low, except frame_start, which deasserts after one clk.
REQ-025 SHALL take effect for blank_en at stage 2 on the next pix_ce; counters and addresses are unaffected.

Reset
REQ-026 SHALL, while rst is low, force h_cnt=0, v_cnt=0, rom_addr=0, RGB=0, de=0, frame_start=0, hsync=1, vsync=1, and clear both pipeline stages.
REQ-027 SHALL restart from (0,0) on the first pix_ce after rst deasserts, including after a reset mid-frame, with no partial-frame outputs.

Structure
REQ-028 SHALL place the default timing constants (H/V active, porch, sync, totals) in shared package vga_timing_pkg.
REQ-029 SHALL instantiate one sub-module, vga_timing, containing the counters, the active decode and the stage-0 sync decode; the address and pixel pipeline stay in the top.

Verification
REQ-030 SHALL verify reset: pix_ce at clk/4, rst low 5 clks then high -> outputs at reset values; first de rise 2 pix ticks after the counters reach (0,0); frame_start pulses once.
REQ-031 SHALL verify the address sequence: ROM model returning data=addr -> line 0 RGB 0..639, line 1 starts at 640, last pixel 307199, next frame at 0.
REQ-032 SHALL verify timing: count over one frame -> 800 ticks per line, hsync low 96 ticks, vsync low 2 lines, de high 640x480 ticks, 420000 ticks per frame.
REQ-033 SHALL verify blanking: blank_en high during line 100 -> RGB 0 for that line only; de, sync and address sequence unchanged.
REQ-034 SHALL verify stall: pix_ce held low 50 clks mid-line -> all outputs frozen, then resuming with no skipped or repeated address.
REQ-035 SHALL verify mid-frame reset: rst low at (320,240) -> outputs at reset values; restart at address 0 with full 525-line frame timing.
